// File: rtl/qsfp_mgmt_seq.sv
// QSFP module management sequencer: debounces module presence, drives the
// ResetL / t_init power-up sequence and reports READY plus interrupt pulses.
module qsfp_mgmt_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned RESET_CYCLES    = 2500,
  parameter int unsigned INIT_CYCLES     = 500000000
) (
  input  logic        clk_250mhz,
  input  logic        rst_250mhz_n,
  input  logic        qsfp_modprsl,
  input  logic        qsfp_intl,
  input  logic        lpmode_req,
  input  logic        soft_reset_req,
  output logic        qsfp_resetl,
  output logic        qsfp_lpmode,
  output logic        qsfp_modsell,
  output logic        module_ready,
  output logic        int_pulse,
  output logic [2:0]  state,
  output logic [15:0] insert_count
);

  typedef enum logic [2:0] {
    ST_ABSENT   = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RESET    = 3'd2,
    ST_INIT     = 3'd3,
    ST_READY    = 3'd4
  } state_t;

  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] RST_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);

  logic        modprsl_meta, modprsl_sync;
  logic        intl_meta, intl_sync, intl_prev;
  state_t      state_reg, state_next;
  logic [31:0] cnt_reg;
  logic [15:0] insert_count_reg;
  logic        prs;

  assign prs          = ~modprsl_sync;
  assign state        = state_reg;
  assign insert_count = insert_count_reg;

  // Loss of presence overrides every other transition.
  always_comb begin
    state_next = state_reg;
    if (state_reg != ST_ABSENT && !prs) begin
      state_next = ST_ABSENT;
    end else begin
      case (state_reg)
        ST_ABSENT:   if (prs) state_next = ST_DEBOUNCE;
        ST_DEBOUNCE: if (cnt_reg == DEB_LAST) state_next = ST_RESET;
        ST_RESET:    if (cnt_reg == RST_LAST) state_next = ST_INIT;
        ST_INIT: begin
          if (soft_reset_req)              state_next = ST_RESET;
          else if (cnt_reg == INIT_LAST)   state_next = ST_READY;
        end
        ST_READY:    if (soft_reset_req) state_next = ST_RESET;
        default:     state_next = ST_ABSENT;
      endcase
    end
  end

  always_ff @(posedge clk_250mhz or negedge rst_250mhz_n) begin
    if (!rst_250mhz_n) begin
      modprsl_meta     <= 1'b1;
      modprsl_sync     <= 1'b1;
      intl_meta        <= 1'b1;
      intl_sync        <= 1'b1;
      intl_prev        <= 1'b1;
      state_reg        <= ST_ABSENT;
      cnt_reg          <= 32'd0;
      insert_count_reg <= 16'd0;
      qsfp_resetl      <= 1'b0;
      qsfp_lpmode      <= 1'b1;
      qsfp_modsell     <= 1'b1;
      module_ready     <= 1'b0;
      int_pulse        <= 1'b0;
    end else begin
      modprsl_meta <= qsfp_modprsl;
      modprsl_sync <= modprsl_meta;
      intl_meta    <= qsfp_intl;
      intl_sync    <= intl_meta;
      intl_prev    <= intl_sync;
      state_reg    <= state_next;

      if (state_next != state_reg)
        cnt_reg <= 32'd0;
      else if (state_reg == ST_DEBOUNCE || state_reg == ST_RESET || state_reg == ST_INIT)
        cnt_reg <= cnt_reg + 32'd1;
      else
        cnt_reg <= 32'd0;

      if (state_reg == ST_DEBOUNCE && state_next == ST_RESET)
        insert_count_reg <= insert_count_reg + 16'd1;

      // Outputs follow the next state so they line up with the state register.
      qsfp_resetl  <= (state_next == ST_INIT) || (state_next == ST_READY);
      qsfp_lpmode  <= (state_next == ST_READY) ? lpmode_req : 1'b1;
      qsfp_modsell <= (state_next != ST_READY);
      module_ready <= (state_next == ST_READY);
      // A low interrupt line seen on READY entry counts as a fresh event.
      int_pulse    <= (state_next == ST_READY) && !intl_sync &&
                      (intl_prev || state_reg != ST_READY);
    end
  end

endmodule

// File: doc/qsfp_mgmt_seq.md
QSFP_MGMT_SEQ -- requirements
Module: qsfp_mgmt_seq

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning module-present debounce time in clk cycles (1 ms); legal range 1..2^32-1.
REQ-002 SHALL have parameter RESET_CYCLES, default 2500, meaning ResetL assertion time in cycles (10 us); legal range 1..2^32-1.
REQ-003 SHALL have parameter INIT_CYCLES, default 500000000, meaning post-reset t_init wait in cycles (2 s); legal range 1..2^32-1.
REQ-004 SHALL have port clk_250mhz, input, 1, the single clock; all logic SHALL be in this domain.
REQ-005 SHALL have port rst_250mhz_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port qsfp_modprsl, input, 1, module present, active-low, asynchronous to clk.
REQ-007 SHALL have port qsfp_intl, input, 1, module interrupt, active-low, asynchronous to clk.
REQ-008 SHALL have port lpmode_req, input, 1, requested low-power mode while READY.
REQ-009 SHALL have port soft_reset_req, input, 1, single-cycle request to re-reset the module.
REQ-010 SHALL have port qsfp_resetl, output, 1, module reset, active-low.
REQ-011 SHALL have port qsfp_lpmode, output, 1, module low-power mode.
REQ-012 SHALL have port qsfp_modsell, output, 1, module select, active-low.
REQ-013 SHALL have port module_ready, output, 1, high only in READY.
REQ-014 SHALL have port int_pulse, output, 1, one-cycle pulse per interrupt event.
REQ-015 SHALL have port state, output, 3, current state encoding.
REQ-016 SHALL have port insert_count, output, 16, count of completed debounces.

Function
REQ-017 SHALL synchronise qsfp_modprsl and qsfp_intl through two flops each (2-cycle latency), reset value 1; the FSM SHALL use only the synchronised values (prs = !modprsl_sync).
REQ-018 SHALL implement the states ABSENT=0, DEBOUNCE=1, RESET=2, INIT=3, READY=4.
REQ-019 SHALL use one 32-bit counter, cleared on every state entry, incremented each cycle in DEBOUNCE/RESET/INIT.
REQ-020 ABSENT: if prs=1, go to DEBOUNCE.
REQ-021 DEBOUNCE: if prs=0, go to ABSENT; else at cnt==DEBOUNCE_CYCLES-1, go to RESET and increment insert_count, which wraps 0xFFFF->0.
REQ-022 RESET SHALL last exactly RESET_CYCLES cycles and then go to INIT.
REQ-023 INIT SHALL last exactly INIT_CYCLES cycles and then go to READY.
REQ-024 In DEBOUNCE, RESET, INIT and READY, prs=0 SHALL force ABSENT next cycle, with priority over every other transition.
REQ-025 soft_reset_req=1 in INIT or READY (with prs=1) SHALL go to RESET with the counter cleared; in other states it SHALL be ignored.
REQ-026 Outputs SHALL be registered from the next state, so they change in the same cycle as state.
REQ-027 qsfp_resetl SHALL be 0 in ABSENT, DEBOUNCE and RESET, and 1 in INIT and READY.
REQ-028 qsfp_lpmode SHALL be 1 outside READY and SHALL equal lpmode_req, delayed 1 cycle, in READY.
REQ-029 qsfp_modsell SHALL be 0 only in READY.
REQ-030 module_ready SHALL equal (state==READY).
REQ-031 int_pulse SHALL be high for one cycle after a 1->0 transition of intl_sync while in READY, including a READY-entry cycle when intl_sync is already 0; it SHALL be 0 outside READY.

Reset
REQ-032 When rst_250mhz_n=0, the block SHALL immediately set state=ABSENT, counter=0, insert_count=0, sync flops=1, qsfp_resetl=0, qsfp_lpmode=1, qsfp_modsell=1, module_ready=0 and int_pulse=0.
REQ-033 Reset release SHALL take effect on the next clk edge.
REQ-034 Reset mid-sequence SHALL abandon the sequence without any glitch to resetl=1.

Verification (DEBOUNCE_CYCLES=4, RESET_CYCLES=8, INIT_CYCLES=16)
REQ-035 Insertion: modprsl 1->0 at cycle 0 -> DEBOUNCE at cycle 3; resetl rises at cycle 15; module_ready=1 at cycle 31; insert_count=1.
REQ-036 Bounce: modprsl low for 3 cycles then high during DEBOUNCE -> return to ABSENT, resetl stays 0, insert_count unchanged.
REQ-037 Removal in INIT: modprsl to 1 -> within 3 cycles state=ABSENT, resetl=0, lpmode=1; reinsertion -> full sequence and insert_count=2.
REQ-038 Interrupt: READY, intl 1->0 -> int_pulse exactly 1 cycle, 3 cycles later; intl held low gives no further pulse.
REQ-039 Soft reset in READY together with lpmode_req=0 -> next cycle state=RESET, resetl=0, lpmode=1; ready again 24 cycles later.
REQ-040 Async reset in READY (rst_250mhz_n low mid-cycle) -> outputs take reset values before the next clk edge; insert_count=0.
